// File: rtl/fb_write_arbiter_pkg.sv
// Shared constants and types for the NES framebuffer write-port arbiter.
package fb_pkg;

  localparam int FB_W     = 256;
  localparam int FB_H     = 240;
  localparam int ADDR_W   = 16;
  localparam int FB_WORDS = 61440;
  localparam logic [ADDR_W-1:0] FB_LAST = 16'hEFFF;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_RUN,
    CLR_DONE
  } clear_state_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Bundles the PPU stream, host channel, clear control and framebuffer port A.
interface fb_write_arbiter_if;
  import fb_pkg::*;

  logic              ppu_valid;
  logic [9:0]        ppu_x;
  logic [9:0]        ppu_y;
  logic [7:0]        ppu_pixel;

  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_data;
  logic              host_err;

  logic              clear_req;
  logic [7:0]        clear_color;
  logic              clear_busy;
  logic              clear_done;

  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_din;

  modport slave (
    input  ppu_valid, ppu_x, ppu_y, ppu_pixel,
    input  host_valid, host_addr, host_data,
    input  clear_req, clear_color,
    output host_ready, host_err, clear_busy, clear_done,
    output fb_we, fb_addr, fb_din
  );

  modport master (
    output ppu_valid, ppu_x, ppu_y, ppu_pixel,
    output host_valid, host_addr, host_data,
    output clear_req, clear_color,
    input  host_ready, host_err, clear_busy, clear_done,
    input  fb_we, fb_addr, fb_din
  );

endinterface

// File: rtl/fb_write_arbiter_clear_engine.sv
// Full-frame clear sweeper: walks 0..FB_LAST with a latched colour whenever granted.
module fb_clear_engine
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        color,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data,
  output logic              busy,
  output logic              done
);

  clear_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg;
  logic [7:0]        color_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= CLR_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CLR_IDLE: if (start) state_next = CLR_RUN;
      CLR_RUN:  if (grant && cnt_reg == FB_LAST) state_next = CLR_DONE;
      CLR_DONE: state_next = CLR_IDLE;
      default:  state_next = CLR_IDLE;
    endcase
  end

  // The counter stops on FB_LAST so it never leaves the visible frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      color_reg <= '0;
    end else if (state_reg == CLR_IDLE && start) begin
      cnt_reg   <= '0;
      color_reg <= color;
    end else if (state_reg == CLR_RUN && grant && cnt_reg != FB_LAST) begin
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    req  = (state_reg == CLR_RUN);
    busy = (state_reg == CLR_RUN);
    done = (state_reg == CLR_DONE);
    addr = cnt_reg;
    data = color_reg;
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Fixed-priority owner of framebuffer port A: PPU over host over clear, one registered write per cycle.
module fb_write_arbiter
  import fb_pkg::*;
(
  input  logic               ppu_clk,
  input  logic               reset,
  fb_write_arbiter_if.slave  bus
);

  logic              ppu_take;
  logic              host_ready_w;
  logic              host_fire;
  logic              host_in_range;
  logic              clr_req;
  logic              clr_grant;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        clr_data;
  logic              clr_busy;
  logic              clr_done;

  logic              fb_we_reg, fb_we_next;
  logic [ADDR_W-1:0] fb_addr_reg, fb_addr_next;
  logic [7:0]        fb_din_reg, fb_din_next;
  logic              host_err_reg, host_err_next;

  // Coordinates are range-checked at full width so x=261 cannot alias onto x=5.
  assign ppu_take      = bus.ppu_valid && (bus.ppu_x < 10'(FB_W)) && (bus.ppu_y < 10'(FB_H));
  assign host_ready_w  = reset & ~ppu_take;
  assign host_fire     = bus.host_valid & host_ready_w;
  assign host_in_range = (bus.host_addr < ADDR_W'(FB_WORDS));
  assign clr_grant     = clr_req & ~ppu_take & ~host_fire;

  fb_clear_engine u_clear (
    .clk   (ppu_clk),
    .reset (reset),
    .start (bus.clear_req),
    .color (bus.clear_color),
    .grant (clr_grant),
    .req   (clr_req),
    .addr  (clr_addr),
    .data  (clr_data),
    .busy  (clr_busy),
    .done  (clr_done)
  );

  always_comb begin
    fb_we_next    = 1'b0;
    fb_addr_next  = fb_addr_reg;
    fb_din_next   = fb_din_reg;
    host_err_next = 1'b0;
    if (ppu_take) begin
      fb_we_next   = 1'b1;
      fb_addr_next = {bus.ppu_y[7:0], bus.ppu_x[7:0]};
      fb_din_next  = bus.ppu_pixel;
    end else if (host_fire) begin
      if (host_in_range) begin
        fb_we_next   = 1'b1;
        fb_addr_next = bus.host_addr;
        fb_din_next  = bus.host_data;
      end else begin
        host_err_next = 1'b1;
      end
    end else if (clr_grant) begin
      fb_we_next   = 1'b1;
      fb_addr_next = clr_addr;
      fb_din_next  = clr_data;
    end
  end

  always_ff @(posedge ppu_clk or negedge reset) begin
    if (!reset) begin
      fb_we_reg    <= 1'b0;
      fb_addr_reg  <= '0;
      fb_din_reg   <= '0;
      host_err_reg <= 1'b0;
    end else begin
      fb_we_reg    <= fb_we_next;
      fb_addr_reg  <= fb_addr_next;
      fb_din_reg   <= fb_din_next;
      host_err_reg <= host_err_next;
    end
  end

  assign bus.host_ready = host_ready_w;
  assign bus.host_err   = host_err_reg;
  assign bus.clear_busy = clr_busy;
  assign bus.clear_done = clr_done;
  assign bus.fb_we      = fb_we_reg;
  assign bus.fb_addr    = fb_addr_reg;
  assign bus.fb_din     = fb_din_reg;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed plus randomized bench for fb_write_arbiter against a frame-level reference model.
module tb_fb_write_arbiter;

  logic ppu_clk = 1'b0;
  logic reset   = 1'b0;
  always #5 ppu_clk = ~ppu_clk;

  fb_write_arbiter_if bus ();

  fb_write_arbiter dut (
    .ppu_clk (ppu_clk),
    .reset   (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an active clear is "next pixel index to paint", nothing more.
  bit          m_active;
  int          m_idx;
  logic [7:0]  m_color;
  bit          m_done;
  bit          m_we;
  bit          m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_din;

  bit          last_fire;
  bit          saw_done;
  int          clear_writes;
  logic [7:0]  count_color;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fb_we"},      32'(bus.fb_we),      0);
    check({tag, "_fb_addr"},    32'(bus.fb_addr),    0);
    check({tag, "_fb_din"},     32'(bus.fb_din),     0);
    check({tag, "_host_err"},   32'(bus.host_err),   0);
    check({tag, "_host_ready"}, 32'(bus.host_ready), 0);
    check({tag, "_clear_busy"}, 32'(bus.clear_busy), 0);
    check({tag, "_clear_done"}, 32'(bus.clear_done), 0);
  endtask

  task automatic model_reset();
    m_active = 0; m_idx = 0; m_color = 8'h00; m_done = 0;
    m_we = 0; m_err = 0; m_addr = 16'h0000; m_din = 8'h00;
    last_fire = 0;
  endtask

  function automatic logic [7:0] rnd_byte(input logic [7:0] avoid);
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == avoid) v = v + 8'd1;
    return v;
  endfunction

  // One clock: predict from the inputs now on the bus, clock, then compare.
  task automatic tick();
    bit take, fire, fin, was_active;
    #1;
    take = bus.ppu_valid && (int'(bus.ppu_x) < 256) && (int'(bus.ppu_y) < 240);
    check("host_ready", 32'(bus.host_ready), 32'(!take));
    fire       = bus.host_valid && !take;
    was_active = m_active;
    fin        = 0;
    m_we       = 0;
    m_err      = 0;
    if (take) begin
      m_we   = 1;
      m_addr = 16'(int'(bus.ppu_y) * 256 + int'(bus.ppu_x));
      m_din  = bus.ppu_pixel;
    end else if (fire) begin
      if (int'(bus.host_addr) < 61440) begin
        m_we   = 1;
        m_addr = bus.host_addr;
        m_din  = bus.host_data;
      end else begin
        m_err = 1;
      end
    end else if (m_active) begin
      m_we   = 1;
      m_addr = 16'(m_idx);
      m_din  = m_color;
      if (m_idx == 61439) begin
        fin      = 1;
        m_active = 0;
      end else begin
        m_idx++;
      end
    end
    if (!was_active && !m_done && bus.clear_req) begin
      m_active = 1;
      m_idx    = 0;
      m_color  = bus.clear_color;
    end
    m_done    = fin;
    last_fire = fire;
    @(posedge ppu_clk);
    @(negedge ppu_clk);
    check("fb_we",      32'(bus.fb_we),      32'(m_we));
    check("fb_addr",    32'(bus.fb_addr),    32'(m_addr));
    check("fb_din",     32'(bus.fb_din),     32'(m_din));
    check("host_err",   32'(bus.host_err),   32'(m_err));
    check("clear_busy", 32'(bus.clear_busy), 32'(m_active));
    check("clear_done", 32'(bus.clear_done), 32'(m_done));
    if (bus.fb_we && bus.fb_din == count_color) clear_writes++;
    if (bus.clear_done) saw_done = 1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.ppu_valid   = 1'b1;
    bus.ppu_x       = 10'd5;
    bus.ppu_y       = 10'd3;
    bus.ppu_pixel   = 8'h2A;
    bus.host_valid  = 1'b0;
    bus.host_addr   = 16'h0000;
    bus.host_data   = 8'h00;
    bus.clear_req   = 1'b0;
    bus.clear_color = 8'h00;
    count_color     = 8'hFF;
    clear_writes    = 0;
    saw_done        = 0;
    model_reset();

    repeat (3) @(posedge ppu_clk);
    @(negedge ppu_clk);
    check_zero("in_reset");
    reset = 1'b1;
    tick();

    // Overscan frees the slot for the host; full-width compare rejects x=261.
    bus.ppu_x = 10'd256; bus.ppu_y = 10'd3;
    bus.host_valid = 1'b1; bus.host_addr = 16'h1234; bus.host_data = 8'h11;
    tick();
    bus.ppu_x = 10'd5; bus.ppu_y = 10'd240;
    bus.host_addr = 16'hF000; bus.host_data = 8'h22;
    tick();
    bus.host_valid = 1'b0;
    bus.ppu_x = 10'd261; bus.ppu_y = 10'd3;
    tick();
    bus.ppu_valid = 1'b0;
    tick();

    // Full clear with stalls, host contention and an ignored second request.
    bus.clear_req = 1'b1; bus.clear_color = 8'h0F;
    count_color = 8'h0F; clear_writes = 0; saw_done = 0;
    tick();
    bus.clear_req = 1'b0;
    cyc = 0;
    while (!saw_done && cyc < 70000) begin
      bus.clear_req = 1'b0;
      if (cyc == 100) begin
        bus.clear_req = 1'b1; bus.clear_color = 8'h55;
      end
      if (cyc >= 200 && cyc < 210) begin
        bus.ppu_valid = 1'b1;
        bus.ppu_x     = 10'($urandom_range(0, 255));
        bus.ppu_y     = 10'($urandom_range(0, 239));
        bus.ppu_pixel = rnd_byte(8'h0F);
      end else if (cyc == 210) begin
        bus.ppu_valid = 1'b0;
      end
      if (cyc == 300) begin
        bus.host_valid = 1'b1;
        bus.host_addr  = 16'($urandom_range(0, 61439));
        bus.host_data  = rnd_byte(8'h0F);
      end else if (cyc == 301) begin
        bus.host_valid = 1'b0;
      end
      if (cyc >= 1000 && cyc < 4000) begin
        bus.ppu_valid = ($urandom_range(0, 3) < 2);
        bus.ppu_x     = 10'($urandom_range(0, 300));
        bus.ppu_y     = 10'($urandom_range(0, 260));
        bus.ppu_pixel = rnd_byte(8'h0F);
        if (!bus.host_valid || last_fire) begin
          bus.host_valid = ($urandom_range(0, 1) == 1);
          bus.host_addr  = 16'($urandom_range(0, 65535));
          bus.host_data  = rnd_byte(8'h0F);
        end
      end else if (cyc == 4000) begin
        bus.ppu_valid = 1'b0;
      end else if (cyc == 4001) begin
        bus.host_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    check("clear_done_seen", 32'(saw_done), 1);
    tick();
    check("clear_total_writes", 32'(clear_writes), 61440);

    // Asynchronous reset in the middle of a clear aborts it for good.
    bus.clear_req = 1'b1; bus.clear_color = 8'h44;
    count_color = 8'h44;
    tick();
    bus.clear_req = 1'b0;
    cyc = 0;
    while (m_idx != 32'h1000 && cyc < 5000) begin
      tick();
      cyc++;
    end
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge ppu_clk);
    @(negedge ppu_clk);
    reset = 1'b1;
    model_reset();
    clear_writes = 0;
    repeat (50) tick();
    check("writes_after_abort", 32'(clear_writes), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
